// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers A rows / B columns and streams them diagonally skewed into an NxN PE array.
// Ports: clk, rst_n (sync, active low); start; wr_en/wr_sel/wr_lane/wr_idx/wr_data buffer write port (IDLE only);
//        busy, done, pe_rst_n (array accumulator clear), array_en; a_lane/b_lane N packed DW-bit edge lanes.
module systolic_feeder #(
    parameter int N         = 4,
    parameter int K         = 4,
    parameter int DW        = 8,
    parameter int DRAIN_CYC = 12
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 wr_en,
    input  logic                                 wr_sel,
    input  logic [(N > 1 ? $clog2(N) : 1)-1:0]  wr_lane,
    input  logic [(K > 1 ? $clog2(K) : 1)-1:0]  wr_idx,
    input  logic [DW-1:0]                        wr_data,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 pe_rst_n,
    output logic                                 array_en,
    output logic [N*DW-1:0]                      a_lane,
    output logic [N*DW-1:0]                      b_lane
);
    localparam int LW   = N > 1 ? $clog2(N) : 1;
    localparam int KW   = K > 1 ? $clog2(K) : 1;
    localparam int CMAX = (K + N > DRAIN_CYC) ? K + N : DRAIN_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [DW-1:0]   a_mem [N][K];
    logic [DW-1:0]   b_mem [N][K];
    logic [N*DW-1:0] a_nxt, b_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt is the FEED slot index t, then reused as the DRAIN cycle index
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE:  state_nxt = start ? CLEAR : IDLE;
            CLEAR: begin
                state_nxt = FEED;
                cnt_nxt   = '0;
            end
            FEED: begin
                state_nxt = (cnt == CW'(K + N - 2)) ? DRAIN : FEED;
                cnt_nxt   = (cnt == CW'(K + N - 2)) ? '0 : cnt + 1'b1;
            end
            DRAIN: begin
                state_nxt = (cnt == CW'(DRAIN_CYC - 1)) ? DONE : DRAIN;
                cnt_nxt   = (cnt == CW'(DRAIN_CYC - 1)) ? '0 : cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Buffers are only writable while idle so a run always sees a stable operand set
    always_ff @(posedge clk) begin
        if (state == IDLE && wr_en && {1'b0, wr_lane} < (LW + 1)'(N) && {1'b0, wr_idx} < (KW + 1)'(K)) begin
            if (wr_sel)
                b_mem[wr_lane][wr_idx] <= wr_data;
            else
                a_mem[wr_lane][wr_idx] <= wr_data;
        end
    end

    // Lanes are computed from the next state/slot so the registered value lines up with its slot.
    // Lane g is delayed by g slots: element index k = t - g, valid when 0 <= k < K.
    for (genvar g = 0; g < N; g++) begin : g_lane
        logic [CW:0] k;
        logic        v;
        assign k = {1'b0, cnt_nxt} - (CW + 1)'(g);
        assign v = state_nxt == FEED && !k[CW] && k < (CW + 1)'(K);
        assign a_nxt[g*DW +: DW] = v ? a_mem[g][k[KW-1:0]] : '0;
        assign b_nxt[g*DW +: DW] = v ? b_mem[g][k[KW-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            pe_rst_n <= 1'b1;
            array_en <= 1'b0;
            a_lane   <= '0;
            b_lane   <= '0;
        end else begin
            busy     <= state_nxt inside {CLEAR, FEED, DRAIN};
            done     <= state_nxt == DONE;
            pe_rst_n <= state_nxt != CLEAR;
            array_en <= state_nxt inside {FEED, DRAIN};
            a_lane   <= a_nxt;
            b_lane   <= b_nxt;
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: scoreboard and table-driven checks of systolic_feeder with a behavioural 4x4 PE array.
module tb_systolic_feeder;
    localparam int N = 4, K = 4, DW = 8, DR = 12;
    localparam int RUN = K + N + DR + 2;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, wr_en = 1'b0, wr_sel = 1'b0;
    logic [1:0] wr_lane = '0, wr_idx = '0;
    logic [7:0] wr_data = '0;
    logic busy, done, pe_rst_n, array_en;
    logic [N*DW-1:0] a_lane, b_lane;

    always #5 clk = ~clk;

    systolic_feeder #(.N(N), .K(K), .DW(DW), .DRAIN_CYC(DR)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_lane(wr_lane), .wr_idx(wr_idx), .wr_data(wr_data), .busy(busy), .done(done),
        .pe_rst_n(pe_rst_n), .array_en(array_en), .a_lane(a_lane), .b_lane(b_lane)
    );

    logic [7:0] ar [N][N];
    logic [7:0] br [N][N];
    int         acc [N][N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!(rst_n && pe_rst_n)) begin
                    ar[i][j]  <= '0;
                    br[i][j]  <= '0;
                    acc[i][j] <= 0;
                end else if (array_en) begin
                    ar[i][j]  <= (j == 0) ? a_lane[i*DW +: DW] : ar[i][j > 0 ? j - 1 : 0];
                    br[i][j]  <= (i == 0) ? b_lane[j*DW +: DW] : br[i > 0 ? i - 1 : 0][j];
                    acc[i][j] <= acc[i][j]
                        + int'((j == 0) ? a_lane[i*DW +: DW] : ar[i][j > 0 ? j - 1 : 0])
                        * int'((i == 0) ? b_lane[j*DW +: DW] : br[i > 0 ? i - 1 : 0][j]);
                end
            end
        end
    end

    typedef struct {
        logic            busy, done, prn, en;
        logic [N*DW-1:0] a, b;
    } exp_t;

    typedef struct {
        int         t;
        logic [7:0] a0, a1, b0, b1;
    } skew_t;

    exp_t            q[$];
    skew_t           tbl[7];
    logic [7:0]      a_ref [N][K];
    logic [7:0]      b_ref [N][K];
    logic [N*DW-1:0] cap_a [RUN+1];
    logic [N*DW-1:0] cap_b [RUN+1];
    int tests = 0, fails = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] lanes(input bit sel, input int t);
        logic [N*DW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < K)
                r[i*DW +: DW] = sel ? b_ref[i][t-i] : a_ref[i][t-i];
        return r;
    endfunction

    task automatic wr(input bit sel, input int lane, input int idx, input logic [7:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_lane = 2'(lane); wr_idx = 2'(idx); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (sel) b_ref[lane][idx] = d;
        else     a_ref[lane][idx] = d;
    endtask

    task automatic do_run(input bit inj, input bit same_wr, input logic [7:0] sv);
        exp_t e;
        int   dc;
        start = 1'b1;
        if (same_wr) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_lane = 2'd3; wr_idx = 2'd3; wr_data = sv;
            a_ref[3][3] = sv;
        end
        for (int c = 1; c <= RUN; c++) begin
            e.busy = c <= K + N + DR;
            e.done = c == K + N + DR + 1;
            e.prn  = c != 1;
            e.en   = c >= 2 && c <= K + N + DR;
            e.a    = (c >= 2 && c <= K + N) ? lanes(0, c - 2) : '0;
            e.b    = (c >= 2 && c <= K + N) ? lanes(1, c - 2) : '0;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        dc = 0;
        for (int c = 1; c <= RUN; c++) begin
            e = q.pop_front();
            chk($sformatf("cyc%0d", c), {busy, done, pe_rst_n, array_en, a_lane, b_lane},
                {e.busy, e.done, e.prn, e.en, e.a, e.b});
            cap_a[c] = a_lane;
            cap_b[c] = b_lane;
            if (done === 1'b1) dc++;
            wr_en = inj && c == 4;
            wr_sel = 1'b0; wr_lane = '0; wr_idx = '0; wr_data = 8'hFF;
            start = inj && c == 12;
            @(negedge clk);
        end
        start = 1'b0;
        wr_en = 1'b0;
        chk("done_pulses", dc, 1);
    endtask

    initial begin
        int dc;
        tbl[0] = '{0, 1, 0,  9,  0};
        tbl[1] = '{1, 2, 5, 10, 13};
        tbl[2] = '{2, 3, 6, 11, 14};
        tbl[3] = '{3, 4, 7, 12, 15};
        tbl[4] = '{4, 0, 8,  0, 16};
        tbl[5] = '{5, 0, 0,  0,  0};
        tbl[6] = '{6, 0, 0,  0,  0};

        rst_n = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst%0d", c), {busy, done, pe_rst_n, array_en, a_lane, b_lane}, {4'b0010, 64'h0});
        end
        rst_n = 1'b1;
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d", c), {busy, done, pe_rst_n, array_en}, 4'b0010);
        end

        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) begin
                wr(0, i, k, i < 2 ? 8'(i * 4 + k + 1) : 8'h0);
                wr(1, i, k, i < 2 ? 8'(i * 4 + k + 9) : 8'h0);
            end

        do_run(0, 0, 8'h0);
        foreach (tbl[n])
            chk($sformatf("skew_t%0d", tbl[n].t),
                {cap_a[tbl[n].t+2][15:0], cap_b[tbl[n].t+2][15:0]},
                {tbl[n].a1, tbl[n].a0, tbl[n].b1, tbl[n].b0});

        do_run(1, 0, 8'h0);
        do_run(0, 1, 8'h2A);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_slot3", {array_en, a_lane, b_lane}, {1'b1, lanes(0, 3), lanes(1, 3)});
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_next", {busy, done, pe_rst_n, array_en, a_lane, b_lane}, {4'b0010, 64'h0});
        rst_n = 1'b1;
        dc = 0;
        repeat (RUN + 3) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) dc++;
        end
        chk("abort_quiet", dc, 0);
        do_run(0, 0, 8'h0);

        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) begin
                wr(0, i, k, i == k ? 8'd1 : 8'd0);
                wr(1, i, k, 8'd3);
            end
        do_run(0, 0, 8'd1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("c3_%0d%0d", i, j), acc[i][j], 3);

        for (int j = 0; j < N; j++)
            for (int k = 0; k < K; k++)
                wr(1, j, k, 8'd2);
        do_run(0, 0, 8'd1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("c2_%0d%0d", i, j), acc[i][j], 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
